// File: rtl/tone_sequencer.sv
// Note sequencer driving the tone clock divider's maxcount from a small note RAM.
// Define TONE_SEQ_GAP_EN to insert a silent GAP_CYCLES interval after every note.
module tone_sequencer #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AW          = 4,
  parameter int unsigned MW          = 17,
  parameter int unsigned NOTE_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 2_500_000
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  input  logic [AW:0]   len,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [MW-1:0] wr_data,
  output logic [MW-1:0] maxcount,
  output logic          tone_en,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] note_idx
);

  if (NOTE_CYCLES < 1 || GAP_CYCLES < 1 || DEPTH > (1 << AW)) begin : g_param_check
    $error("tone_sequencer: illegal parameter combination");
  end

  localparam logic [AW:0] DepthLen = (AW + 1)'(DEPTH);
  localparam logic [31:0] NoteLast = 32'(NOTE_CYCLES - 1);

`ifdef TONE_SEQ_GAP_EN
  localparam logic [31:0] GapLast = 32'(GAP_CYCLES - 1);
  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;
`else
  typedef enum logic [1:0] {StIdle, StPlay} state_e;
`endif

  state_e        state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   timer_q, timer_d;
  logic [MW-1:0] maxcount_q, maxcount_d;
  logic          tone_en_q, tone_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] rd_data;
  logic [AW:0]   len_clamp;
  logic [AW:0]   idx_next;
  logic          advance;
  logic          load_note;

  always_ff @(posedge CLK) begin
    if (wr_en && state_q == StIdle) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    maxcount_d = maxcount_q;
    tone_en_d  = tone_en_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    advance    = 1'b0;
    load_note  = 1'b0;
    len_clamp  = (len > DepthLen) ? DepthLen : len;
    idx_next   = {1'b0, idx_q} + {{AW{1'b0}}, 1'b1};

    case (state_q)
      StIdle: begin
        if (start && !stop) begin
          len_d = len_clamp;
          if (len_clamp == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = StPlay;
            idx_d     = '0;
            timer_d   = '0;
            busy_d    = 1'b1;
            load_note = 1'b1;
          end
        end
      end
      StPlay: begin
        if (timer_q == NoteLast) begin
`ifdef TONE_SEQ_GAP_EN
          state_d    = StGap;
          timer_d    = '0;
          maxcount_d = '0;
          tone_en_d  = 1'b0;
`else
          advance = 1'b1;
`endif
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
`ifdef TONE_SEQ_GAP_EN
      StGap: begin
        if (timer_q == GapLast) begin
          advance = 1'b1;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    if (advance) begin
      timer_d = '0;
      if (idx_next < len_q) begin
        state_d   = StPlay;
        idx_d     = idx_next[AW-1:0];
        load_note = 1'b1;
      end else if (loop) begin
        state_d   = StPlay;
        idx_d     = '0;
        load_note = 1'b1;
      end else begin
        state_d    = StIdle;
        idx_d      = '0;
        busy_d     = 1'b0;
        maxcount_d = '0;
        tone_en_d  = 1'b0;
        done_d     = 1'b1;
      end
    end

    // Forward a same-cycle write so a start sees the value being written.
    rd_data = mem[idx_d];
    if (wr_en && state_q == StIdle && wr_addr == idx_d) begin
      rd_data = wr_data;
    end
    if (load_note) begin
      maxcount_d = rd_data;
      tone_en_d  = (rd_data != '0);
    end

    if (stop && state_q != StIdle) begin
      state_d    = StIdle;
      idx_d      = '0;
      timer_d    = '0;
      busy_d     = 1'b0;
      maxcount_d = '0;
      tone_en_d  = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      len_q      <= '0;
      idx_q      <= '0;
      timer_q    <= '0;
      maxcount_q <= '0;
      tone_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      maxcount_q <= maxcount_d;
      tone_en_q  <= tone_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign maxcount = maxcount_q;
  assign tone_en  = tone_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign note_idx = idx_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed self-checking bench for tone_sequencer with NOTE_CYCLES=4, GAP_CYCLES=2.
module tb_tone_sequencer;

  localparam int unsigned AW = 4;
  localparam int unsigned MW = 17;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          start, stop, loop, wr_en;
  logic [AW:0]   len;
  logic [AW-1:0] wr_addr;
  logic [MW-1:0] wr_data;
  logic [MW-1:0] maxcount;
  logic          tone_en, busy, done;
  logic [AW-1:0] note_idx;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned exp_notes [16];

  tone_sequencer #(
    .DEPTH      (16),
    .AW         (AW),
    .MW         (MW),
    .NOTE_CYCLES(4),
    .GAP_CYCLES (2)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .start   (start),
    .stop    (stop),
    .loop    (loop),
    .len     (len),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .maxcount(maxcount),
    .tone_en (tone_en),
    .busy    (busy),
    .done    (done),
    .note_idx(note_idx)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_slot(input int unsigned addr, input int unsigned data);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = MW'(data);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic check_idle(input string tag, input logic exp_done);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_maxcount"}, 32'(maxcount), 32'd0);
    check({tag, "_tone_en"}, 32'(tone_en), 32'd0);
    check({tag, "_note_idx"}, 32'(note_idx), 32'd0);
  endtask

  // One note held four cycles, then the optional silent gap.
  task automatic check_note(input int unsigned idx, input int unsigned val);
    for (int c = 0; c < 4; c++) begin
      check("note_maxcount", 32'(maxcount), 32'(val));
      check("note_tone_en", 32'(tone_en), 32'(val != 0));
      check("note_busy", 32'(busy), 32'd1);
      check("note_idx", 32'(note_idx), 32'(idx));
      check("note_done", 32'(done), 32'd0);
      tick();
      wr_en = 1'b0;
    end
`ifdef TONE_SEQ_GAP_EN
    for (int g = 0; g < 2; g++) begin
      check("gap_maxcount", 32'(maxcount), 32'd0);
      check("gap_tone_en", 32'(tone_en), 32'd0);
      check("gap_busy", 32'(busy), 32'd1);
      check("gap_idx", 32'(note_idx), 32'(idx));
      tick();
    end
`endif
  endtask

  task automatic run_seq(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      check_note(i, exp_notes[i]);
    end
    check_idle("end", 1'b1);
    tick();
    check_idle("after_done", 1'b0);
  endtask

  task automatic do_start(input int unsigned l);
    len   = (AW + 1)'(l);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; start = 1'b1; stop = 1'b0; loop = 1'b0; len = 5'd3;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;

    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("reset", 1'b0);
    end
    RST_N = 1'b1;
    start = 1'b0;
    tick();
    check_idle("post_reset", 1'b0);

    // Basic program; a write attempted during playback must be dropped.
    write_slot(0, 1000);
    write_slot(1, 0);
    write_slot(2, 3000);
    exp_notes[0] = 1000; exp_notes[1] = 0; exp_notes[2] = 3000;
    do_start(3);
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 17'd9999;
    run_seq(3);

    // Replay: slot 1 still a rest.
    do_start(3);
    run_seq(3);

    // Loop then stop mid-note.
    write_slot(0, 500);
    write_slot(1, 700);
    loop = 1'b1;
    do_start(2);
    check_note(0, 500);
    check_note(1, 700);
    for (int c = 0; c < 2; c++) begin
      check("wrap_maxcount", 32'(maxcount), 32'd500);
      check("wrap_idx", 32'(note_idx), 32'd0);
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    loop = 1'b0;
    check_idle("stopped", 1'b0);
    tick();
    check_idle("stopped_next", 1'b0);

    // len=0: done one cycle later, never busy.
    do_start(0);
    check_idle("len0", 1'b1);
    tick();
    check_idle("len0_next", 1'b0);

    // len=20 clamps to 16 slots.
    for (int unsigned i = 0; i < 16; i++) begin
      write_slot(i, 100 + i);
      exp_notes[i] = 100 + i;
    end
    do_start(20);
    run_seq(16);

    // start and stop together: nothing starts.
    stop = 1'b1;
    do_start(3);
    stop = 1'b0;
    check_idle("start_stop", 1'b0);
    tick();
    check_idle("start_stop_next", 1'b0);

    // Write and start in the same cycle: new value plays.
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 17'd4242;
    exp_notes[0] = 4242;
    do_start(1);
    wr_en = 1'b0;
    run_seq(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
